// File: rtl/reg_file_32x32.sv
// reg_file_32x32: 32 x 32-bit register file with two strobed, registered
// read ports and one synchronous write port. Register 0 is hard-wired to
// zero and is not stored. The stack-pointer register resets to SP_RESET.
// A write and a read of the same non-zero address at one edge returns the
// data being written (write-through bypass).
module reg_file_32x32 #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    SP_INDEX   = 29,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = 32'h03FF_FFFF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2,
  output logic                  RD_VALID
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  // Storage for registers 1..NUM_REGS-1; register 0 has no flops.
  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

  // Full 0..NUM_REGS-1 view presented to the read-select muxes.
  logic [DATA_WIDTH-1:0] reg_view_s [0:NUM_REGS-1];

  logic [DATA_WIDTH-1:0] data_r1_q, data_r1_d;
  logic [DATA_WIDTH-1:0] data_r2_q, data_r2_d;
  logic                  rd_valid_q, rd_valid_d;

  // Writes to address 0 are dropped here so neither storage nor bypass sees them.
  logic wr_en_s;
  logic byp_r1_s;
  logic byp_r2_s;

  assign wr_en_s  = WRITE && (ADDR_W != {ADDR_WIDTH{1'b0}});
  assign byp_r1_s = wr_en_s && (ADDR_W == ADDR_R1);
  assign byp_r2_s = wr_en_s && (ADDR_W == ADDR_R2);

  // Build the mux-input view: constant zero at index 0, stored values above.
  always_comb begin
    reg_view_s[0] = {DATA_WIDTH{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      reg_view_s[i] = regs_q[i];
    end
  end

  // Next-state of the storage array: at most one register takes DATA_W.
  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      if (wr_en_s && (ADDR_W == ADDR_WIDTH'(i))) begin
        regs_d[i] = DATA_W;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Next-state of the read ports: select or bypass on READ, otherwise hold.
  always_comb begin
    data_r1_d  = data_r1_q;
    data_r2_d  = data_r2_q;
    rd_valid_d = READ;
    if (READ) begin
      if (byp_r1_s) begin
        data_r1_d = DATA_W;
      end else begin
        data_r1_d = reg_view_s[ADDR_R1];
      end
      if (byp_r2_s) begin
        data_r2_d = DATA_W;
      end else begin
        data_r2_d = reg_view_s[ADDR_R2];
      end
    end else begin
      data_r1_d = data_r1_q;
      data_r2_d = data_r2_q;
    end
  end

  // State registers; reset loads zeros everywhere except the stack pointer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_INDEX) ? SP_RESET : {DATA_WIDTH{1'b0}};
      end
      data_r1_q  <= {DATA_WIDTH{1'b0}};
      data_r2_q  <= {DATA_WIDTH{1'b0}};
      rd_valid_q <= 1'b0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      data_r1_q  <= data_r1_d;
      data_r2_q  <= data_r2_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign DATA_R1  = data_r1_q;
  assign DATA_R2  = data_r2_q;
  assign RD_VALID = rd_valid_q;

endmodule
